seq_serializer: RTL and testbench
=================================

# seq_serializer

Parallel-to-serial source feeding the `1101` sequence detector. It accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per bit-period on `sout`. Bit order is selectable per word. Back-to-back words stream with no idle gap, so the detector sees a continuous bit stream. `sout` connects directly to the detector's `in`; both blocks share `clk` and `rst`.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word, ≥2.
- `DIV`, default 1: clock cycles each bit is held on `sout`, ≥1.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `load`  input  1: request to accept `din`; honoured only when `ready`=1.
- `din`  input  WIDTH: word to serialize; sampled on the accepting edge.
- `lsb_first`  input  1: bit order, sampled with `din`. 0 = MSB first, 1 = LSB first.
- `ready`  output  1: block can accept `load` this cycle.
- `sout`  output  1: serial data bit; drives the detector's `in`.
- `sout_valid`  output  1: `sout` carries a word bit this cycle.
- `bit_strobe`  output  1: high on the first cycle of each bit period.
- `done`  output  1: one-cycle pulse after the last bit period of a word ends.

## Operation
- States: IDLE and SHIFT.
- Internal registers: shift register (WIDTH), order flag, bit index 0..WIDTH-1, divider count 0..DIV-1. The divider counter is at least 1 bit wide.
- IDLE:
  - `ready`=1, `sout`=0, `sout_valid`=0, `bit_strobe`=0.
  - On `load`=1, capture `din`/`lsb_first`, clear both counters, go to SHIFT.
- SHIFT:
  - `sout` = shift-register MSB when MSB-first, LSB when LSB-first. `sout_valid`=1.
  - `bit_strobe`=1 when divider count = 0.
  - Divider counts 0..DIV-1. On wrap, the register shifts one place toward the output end and the bit index increments.
- Final cycle: bit index = WIDTH-1 and divider count = DIV-1. `ready`=1 in this cycle (combinational from state and counters).
  - If `load`=1 in the final cycle: capture the new word and stay in SHIFT. The first new bit appears on the next cycle, with no gap.
  - Otherwise: go to IDLE.
- `done` is registered. It is 1 for exactly the one cycle after each final cycle, whether or not a reload occurred.
- `load` while `ready`=0 is ignored; `din` and `lsb_first` are don't-care then.
- Reset mid-word: the word is discarded, the state returns to IDLE, and no `done` pulse is produced for the aborted word.
- `rst` has priority over `load` in the same cycle.

## Timing
- Reset values, from the edge where `rst`=1:
  - state IDLE, `ready`=1, `sout`=0, `sout_valid`=0, `bit_strobe`=0, `done`=0.
  - Shift register and counters cleared.
- Latency: `load` accepted at edge k → first bit on `sout` from edge k to edge k+DIV. Bit i occupies cycles k+i·DIV .. k+(i+1)·DIV-1.
- Word duration: WIDTH·DIV cycles. `done`=1 in cycle k+WIDTH·DIV.
- Streaming throughput: one bit per DIV cycles, sustained indefinitely with a reload on every final cycle.
- With DIV=1: `bit_strobe`=`sout_valid` every cycle, and the detector sees one new bit per clock.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `load`=1 → `ready`=1, `sout`=0, `sout_valid`=0, `done`=0, and no word is accepted.
- WIDTH=8, DIV=1, `lsb_first`=0, `din`=8'hD0 → `sout`=1,1,0,1,0,0,0,0 on 8 consecutive cycles; `ready`=1 on the 8th; `done` on the 9th. The attached detector fires exactly once, on the 4th bit.
- `lsb_first`=1, `din`=8'h0B → `sout`=1,1,0,1,0,0,0,0; `done` after 8 bits.
- Back-to-back: load 8'hD0, then load 8'hA5 in the final cycle → 16 contiguous valid bits (11010000 10100101), no `sout_valid` gap, and `done` pulses at cycles 8 and 16 after the first accept.
- DIV=3, `din`=8'hD0 → each bit held 3 cycles; `bit_strobe` on the 1st of every 3; `done` 24 cycles after accept.
- Robustness:
  - Pulse `load` with `din`=8'hFF during bit 2 → the stream is unchanged.
  - Assert `rst` during bit 4 → idle outputs on the next cycle, and no `done` pulse.

Source files
------------

// File: rtl/seq_serializer_if.sv
// Load/ready word handshake and serial output bundle for seq_serializer.
// The master side supplies words; the slave side (serializer) drives the bit stream.
interface seq_serializer_if #(
   parameter int WIDTH = 8
) ();
   logic             load;
   logic [WIDTH-1:0] din;
   logic             lsb_first;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             bit_strobe;
   logic             done;

   modport master (
      output load, din, lsb_first,
      input  ready, sout, sout_valid, bit_strobe, done
   );

   modport slave (
      input  load, din, lsb_first,
      output ready, sout, sout_valid, bit_strobe, done
   );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial word source; each bit is held DIV clocks on sout.
// A reload in the final cycle streams the next word with no idle gap.
module seq_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 1
) (
   input  logic           clk,
   input  logic           rst,
   seq_serializer_if.slave bus
);
   localparam int IW = $clog2(WIDTH);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             lsb_q, lsb_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DW-1:0]    div_q, div_d;
   logic             done_q, done_d;

   logic div_wrap;
   logic last_cyc;
   logic rdy;
   logic accept;

   assign div_wrap = (div_q == DIV_LAST);
   assign last_cyc = (state_q == SHIFT) && (idx_q == IDX_LAST) && div_wrap;
   assign rdy      = (state_q == IDLE) || last_cyc;
   assign accept   = bus.load && rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         lsb_q   <= 1'b0;
         idx_q   <= '0;
         div_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         lsb_q   <= lsb_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      lsb_d   = lsb_q;
      idx_d   = idx_q;
      div_d   = div_q;
      done_d  = last_cyc;
      if (accept) begin
         state_d = SHIFT;
         sreg_d  = bus.din;
         lsb_d   = bus.lsb_first;
         idx_d   = '0;
         div_d   = '0;
      end else if (state_q == SHIFT) begin
         if (last_cyc) begin
            state_d = IDLE;
         end else if (div_wrap) begin
            div_d  = '0;
            idx_d  = idx_q + 1'b1;
            // move the next bit toward whichever end feeds sout
            sreg_d = lsb_q ? (sreg_q >> 1) : (sreg_q << 1);
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_comb begin
      bus.ready      = rdy;
      bus.sout       = 1'b0;
      bus.sout_valid = 1'b0;
      bus.bit_strobe = 1'b0;
      bus.done       = done_q;
      if (state_q == SHIFT) begin
         bus.sout       = lsb_q ? sreg_q[0] : sreg_q[WIDTH-1];
         bus.sout_valid = 1'b1;
         bus.bit_strobe = (div_q == '0);
      end
   end
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: DIV=1 and DIV=3 instances on one clock,
// with a small 1101 detector model watching the DIV=1 stream.
module tb_seq_serializer;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [3:0] hist;
   int   hits;
   int   hit_pos;

   seq_serializer_if #(.WIDTH(8)) ifa ();
   seq_serializer_if #(.WIDTH(8)) ifb ();

   seq_serializer #(.WIDTH(8), .DIV(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   seq_serializer #(.WIDTH(8), .DIV(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_n(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic accept_a(input logic [7:0] d, input logic l);
      ifa.load      = 1'b1;
      ifa.din       = d;
      ifa.lsb_first = l;
      step();
      ifa.load = 1'b0;
   endtask

   task automatic word_a(input string tag, input logic [7:0] exp,
                         input bit pd, input bit reload,
                         input logic [7:0] nd, input logic nl,
                         input int glitch);
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_sout"}, ifa.sout, exp[7-i]);
         chk({tag, "_valid"}, ifa.sout_valid, 1'b1);
         chk({tag, "_strobe"}, ifa.bit_strobe, 1'b1);
         chk({tag, "_ready"}, ifa.ready, i == 7);
         chk({tag, "_done"}, ifa.done, (i == 0) && pd);
         hist = {hist[2:0], ifa.sout};
         if (hist == 4'b1101) begin
            hits++;
            hit_pos = i;
         end
         ifa.load = 1'b0;
         if (reload && i == 7) begin
            ifa.load      = 1'b1;
            ifa.din       = nd;
            ifa.lsb_first = nl;
         end else if (i == glitch) begin
            ifa.load      = 1'b1;
            ifa.din       = 8'hFF;
            ifa.lsb_first = 1'b1;
         end
         step();
      end
      ifa.load = 1'b0;
   endtask

   task automatic idle_a(input string tag, input logic exp_done);
      chk({tag, "_done"}, ifa.done, exp_done);
      chk({tag, "_valid"}, ifa.sout_valid, 1'b0);
      chk({tag, "_sout"}, ifa.sout, 1'b0);
      chk({tag, "_ready"}, ifa.ready, 1'b1);
      chk({tag, "_strobe"}, ifa.bit_strobe, 1'b0);
   endtask

   initial begin
      logic [7:0] wb;
      checks        = 0;
      failures      = 0;
      hist          = 4'b0000;
      hits          = 0;
      hit_pos       = -1;
      rst           = 1'b1;
      ifa.load      = 1'b1;
      ifa.din       = 8'hFF;
      ifa.lsb_first = 1'b0;
      ifb.load      = 1'b1;
      ifb.din       = 8'hFF;
      ifb.lsb_first = 1'b0;

      step();
      step();
      idle_a("rst", 1'b0);
      chk("rst_b_ready", ifb.ready, 1'b1);
      chk("rst_b_valid", ifb.sout_valid, 1'b0);
      chk("rst_b_done", ifb.done, 1'b0);
      rst      = 1'b0;
      ifa.load = 1'b0;
      ifb.load = 1'b0;
      step();
      idle_a("rst_noacc", 1'b0);
      chk("rst_noacc_b", ifb.sout_valid, 1'b0);

      hist = 4'b0000;
      hits = 0;
      accept_a(8'hD0, 1'b0);
      word_a("msb_d0", 8'b1101_0000, 1'b0, 1'b0, 8'h00, 1'b0, -1);
      idle_a("msb_d0_end", 1'b1);
      chk_n("det_hits", hits, 1);
      chk_n("det_pos", hit_pos, 3);
      step();
      idle_a("msb_d0_after", 1'b0);

      accept_a(8'h0B, 1'b1);
      word_a("lsb_0b", 8'b1101_0000, 1'b0, 1'b0, 8'h00, 1'b0, -1);
      idle_a("lsb_0b_end", 1'b1);
      step();

      accept_a(8'hD0, 1'b0);
      word_a("b2b_w0", 8'b1101_0000, 1'b0, 1'b1, 8'hA5, 1'b0, -1);
      word_a("b2b_w1", 8'b1010_0101, 1'b1, 1'b0, 8'h00, 1'b0, -1);
      idle_a("b2b_end", 1'b1);
      step();

      accept_a(8'hD0, 1'b0);
      word_a("glitch", 8'b1101_0000, 1'b0, 1'b0, 8'h00, 1'b0, 2);
      idle_a("glitch_end", 1'b1);
      step();

      accept_a(8'hD0, 1'b0);
      wb = 8'b1101_0000;
      for (int i = 0; i < 4; i++) begin
         chk("abort_sout", ifa.sout, wb[7-i]);
         chk("abort_valid", ifa.sout_valid, 1'b1);
         step();
      end
      chk("abort_bit4_valid", ifa.sout_valid, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_a("abort_rst", 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_nodone", ifa.done, 1'b0);
         chk("abort_novalid", ifa.sout_valid, 1'b0);
      end

      ifb.load      = 1'b1;
      ifb.din       = 8'hD0;
      ifb.lsb_first = 1'b0;
      step();
      ifb.load = 1'b0;
      for (int i = 0; i < 24; i++) begin
         chk("div3_sout", ifb.sout, wb[7 - i/3]);
         chk("div3_valid", ifb.sout_valid, 1'b1);
         chk("div3_strobe", ifb.bit_strobe, (i % 3) == 0);
         chk("div3_ready", ifb.ready, i == 23);
         chk("div3_done", ifb.done, 1'b0);
         step();
      end
      chk("div3_done_end", ifb.done, 1'b1);
      chk("div3_idle_end", ifb.sout_valid, 1'b0);
      step();
      chk("div3_done_off", ifb.done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
